// File: rtl/dds_gen.sv
// rtl/dds_gen.sv - parametrised pipelined direct digital synthesiser with load handshake
module dds_gen #(
    parameter int ACC_W  = 32,
    parameter int LUT_AW = 8,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [ACC_W-1:0]  ftw,
    input  logic [ACC_W-1:0]  pofs,
    input  logic [1:0]        mode,
    input  logic [8:0]        amp,
    input  logic              sync_wrap,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              phase_clr,
    output logic [LUT_AW-1:0] lut_addr,
    input  logic [OUT_W-1:0]  lut_data,
    output logic [OUT_W-1:0]  out,
    output logic              out_valid,
    output logic              wrap
);

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_SAW    = 2'd2,
        MODE_TRI    = 2'd3
    } mode_t;

    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};
    localparam int PW = OUT_W + 11;

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] ftw_a, pofs_a, ftw_s, pofs_s;
    mode_t            mode_a, mode_s, m1;
    logic             pending;
    logic [ACC_W-1:0] p1;
    logic [OUT_W-1:0] w2, w2_next, tri_t;
    logic             v1, v2;

    logic [ACC_W:0]   acc_sum;
    logic             carry, accept, commit;

    logic [8:0]            amp_sat;
    logic signed [OUT_W:0] dev;
    logic signed [PW-1:0]  prod, scaled;
    logic [OUT_W-1:0]      out_next;

    assign ld_ready = !pending;
    assign accept   = ld_valid && ld_ready;
    assign acc_sum  = {1'b0, acc} + {1'b0, ftw_a};
    assign carry    = en && acc_sum[ACC_W];
    // A zero word never wraps, so it must release a pending bundle on its own
    assign commit   = pending && (phase_clr || (ftw_a == '0) || carry);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_a  <= '0;
            pofs_a <= '0;
            mode_a <= MODE_SINE;
        end else if (accept && !sync_wrap) begin
            ftw_a  <= ftw;
            pofs_a <= pofs;
            mode_a <= mode_t'(mode);
        end else if (commit) begin
            ftw_a  <= ftw_s;
            pofs_a <= pofs_s;
            mode_a <= mode_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ftw_s   <= '0;
            pofs_s  <= '0;
            mode_s  <= MODE_SINE;
            pending <= 1'b0;
        end else if (accept && sync_wrap) begin
            ftw_s   <= ftw;
            pofs_s  <= pofs;
            mode_s  <= mode_t'(mode);
            pending <= 1'b1;
        end else if (commit) begin
            pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (phase_clr) begin
            acc  <= '0;
            wrap <= 1'b0;
        end else if (en) begin
            acc  <= acc_sum[ACC_W-1:0];
            wrap <= acc_sum[ACC_W];
        end else begin
            wrap <= 1'b0;
        end
    end

    // Stage 1: offset phase and the mode that travels with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1 <= '0;
            m1 <= MODE_SINE;
            v1 <= 1'b0;
        end else begin
            p1 <= acc + pofs_a;
            m1 <= mode_a;
            v1 <= en;
        end
    end

    assign lut_addr = p1[ACC_W-1 -: LUT_AW];

    always_comb begin
        tri_t   = p1[ACC_W-2 -: OUT_W];
        w2_next = '0;
        case (m1)
            MODE_SINE:   w2_next = lut_data;
            MODE_SQUARE: w2_next = p1[ACC_W-1] ? {OUT_W{1'b1}} : {OUT_W{1'b0}};
            MODE_SAW:    w2_next = p1[ACC_W-1 -: OUT_W];
            MODE_TRI:    w2_next = p1[ACC_W-1] ? ~tri_t : tri_t;
            default:     w2_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w2 <= '0;
            v2 <= 1'b0;
        end else begin
            w2 <= w2_next;
            v2 <= v1;
        end
    end

    // Stage 3: scale the deviation from mid-scale; arithmetic shift floors toward -inf
    assign amp_sat  = (amp > 9'd256) ? 9'd256 : amp;
    assign dev      = $signed({1'b0, w2}) - $signed({1'b0, MID});
    assign prod     = PW'(dev) * PW'($signed({1'b0, amp_sat}));
    assign scaled   = prod >>> 8;
    assign out_next = MID + scaled[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            out       <= v2 ? out_next : '0;
            out_valid <= v2;
        end
    end

endmodule

// File: doc/dds_gen.md
# dds_gen

Parametrised direct digital synthesiser, the next generation of the `dds` tone block. It keeps the phase-accumulator architecture and adds generic accumulator and output widths, four waveform modes, phase offset, amplitude scaling, a valid/ready load handshake with optional phase-continuous commit at accumulator wrap, synchronous phase clear, and a fully synchronous, pipelined datapath. The sine table sits outside the block and is reached through `lut_addr`/`lut_data`, so the LUT can be swapped per target. `dds_gen` sits between the control registers and the DAC/PWM output stage.

## Interface
- `ACC_W`, default 32: phase accumulator width; must be ≥ `OUT_W`+2.
- `LUT_AW`, default 8: sine LUT address width; must be ≤ `ACC_W`.
- `OUT_W`, default 8: sample width, unsigned offset-binary.
- `clk`  in  1: single clock, all state on its rising edge.
- `rst_n`  in  1: reset, asynchronous assert, active low.
- `en`  in  1: 1 = run; 0 = freeze accumulator and blank the output.
- `ftw`  in  `ACC_W`: frequency tuning word; part of the load bundle.
- `pofs`  in  `ACC_W`: phase offset; part of the load bundle.
- `mode`  in  2: waveform, 0 sine, 1 square, 2 sawtooth, 3 triangle; part of the load bundle.
- `amp`  in  9: amplitude, 256 = unity; values above 256 saturate to 256. Sampled every cycle; not part of the load bundle.
- `sync_wrap`  in  1: 0 = commit a load immediately; 1 = commit at the next accumulator wrap.
- `ld_valid`  in  1: load request.
- `ld_ready`  out  1: block can accept a load.
- `phase_clr`  in  1: synchronous accumulator clear.
- `lut_addr`  out  `LUT_AW`: sine LUT address, driven combinationally from the stage-1 register.
- `lut_data`  in  `OUT_W`: sine LUT data; the LUT must be combinational.
- `out`  out  `OUT_W`: output sample.
- `out_valid`  out  1: `out` carries a live sample.
- `wrap`  out  1: one-cycle pulse, the cycle after the accumulator overflows.

## Operation
- **Active registers.** `ftw_a`, `pofs_a` and `mode_a` drive the datapath.
  - A load is accepted on an edge where `ld_valid && ld_ready`.
- **Immediate commit (`sync_wrap`=0).** The accepting edge writes the bundle straight into the active registers. `ld_ready` stays 1.
- **Wrap commit (`sync_wrap`=1).** The accepting edge writes the bundle into shadow registers and sets `pending`; `ld_ready` = !`pending`.
  - The shadow bundle commits on the edge where `en` is high and `acc`+`ftw_a` carries out of `ACC_W` bits. That edge still uses the old `ftw_a`; the new word applies from the next increment.
  - It also commits on any edge where `phase_clr` is high, or where `ftw_a`==0 (a zero word can never wrap, so this avoids deadlock).
  - The commit clears `pending`.
- **Accumulator.** On each edge, in priority order:
  - `phase_clr` high: `acc` ← 0, `wrap` ← 0.
  - else `en` high: `acc` ← (`acc`+`ftw_a`) mod 2^`ACC_W`, `wrap` ← carry.
  - else: `acc` holds, `wrap` ← 0.
- **Stage 1.** `p1` ← `acc`+`pofs_a` (mod 2^`ACC_W`), `m1` ← `mode_a`. `lut_addr` = `p1`[`ACC_W`-1 -: `LUT_AW`].
- **Stage 2.** `w2` is registered, selected by `m1`:
  - sine: `lut_data`
  - square: all ones if `p1`[MSB] is set, else 0
  - sawtooth: `p1`[`ACC_W`-1 -: `OUT_W`]
  - triangle: t = `p1`[`ACC_W`-2 -: `OUT_W`]; output is `p1`[MSB] ? ~t : t
- **Stage 3 (amplitude).**
  - mid = 2^(`OUT_W`-1); d = `w2`−mid as a signed value.
  - `out` ← mid + ((d·amp_sat) >>> 8), using an arithmetic shift, when the valid bit is set; `out` ← 0 otherwise.
- **Valid pipe.** `v1` ← `en`, `v2` ← `v1`, `out_valid` ← `v2`.
- **Reset.** All of the following go to 0: `acc`, active and shadow registers, `pending`, `p1`, `m1`, `w2`, `v1`, `v2`, `out`, `out_valid`, `wrap`. `ld_ready` = 1.
  - An asynchronous reset mid-load discards the pending bundle.

## Timing
- **Latency.** The `acc` value registered at edge n appears in `out` at edge n+3.
  - `out_valid` rises 3 cycles after `en` rises and falls 3 cycles after `en` falls.
- **Immediate load** accepted at edge k: `ftw_a` is effective for the increment at edge k+1. The new `pofs`/`mode` appear in `out` at edge k+3.
- **`phase_clr`** high at edge k: `acc`=0 after edge k; `out` reflects phase `pofs_a` at edge k+3.
- **Load and `phase_clr` on the same edge, `sync_wrap`=0:** both take effect; `acc`=0 and the new bundle is active.
- **`ld_valid` while `pending`:** ignored (not accepted); the caller holds `ld_valid` until `ld_ready`.
- **Saturation.** `amp` ≥ 256 behaves exactly as 256. With `amp`=0, `out` = mid whenever valid.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-run, then release → `out`=0, `out_valid`=0, `wrap`=0, `ld_ready`=1; `acc`=0 (first sawtooth sample = 0).
- **Sawtooth.** Defaults, mode 2, `ftw`=0x01000000, `amp`=256, `en`=1 → `out` = 0,1,2,…,255,0 from the 3rd cycle; `wrap` pulses once every 256 cycles.
- **Square with scaling.** Mode 1, `ftw`=0x40000000 → `out` = 0,0,255,255 repeating. With `amp`=128 → 64,64,191,191. With `amp`=300 → same as 256.
- **Wrap commit.** Active `ftw`=0x40000000, `sync_wrap`=1; load `ftw`=0x80000000 with `acc`=0x40000000 → `ld_ready`=0 for 3 cycles; commit on the wrap edge; `acc` then steps 0, 0x80000000, 0; `ld_ready` returns to 1.
- **Sine path and offset.** Mode 0, `pofs`=0x80000000, `ftw`=0, `phase_clr` pulse → `lut_addr`=0x80 steady; `out`=`lut_data` when `amp`=256.
- **Deadlock escape and blanking.** Active `ftw`=0, `sync_wrap`=1; a load commits on the next edge. Then `en`=0 → `acc` frozen, `out`=0 and `out_valid`=0 after 3 cycles.
